// File: rtl/data_mem_responder_if.sv
// Request/response channel between the memory-access stage (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
  logic [31:0] Mem_Addr;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  logic [31:0] Acc_Cnt;

  modport master (
    output Mem_Addr, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid, Acc_Cnt
  );

  modport slave (
    input  Mem_Addr, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid, Acc_Cnt
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-side word RAM with byte-strobed stores and programmable response
// latency, answering the pipeline's memory request/response channels.
module data_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave mem
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RLAT, S_RESP} state_t;

  localparam logic [3:0] LAT_V = 4'(LAT);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       ram [2**ADDR_W];
  logic [31:0]       rdr;
  logic [31:0]       acc_cnt;
  logic              do_write, do_read, capture;
  logic              unused_addr_bits;

  // Higher address bits alias, byte offset is ignored.
  assign req_idx          = mem.Mem_Addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{mem.Mem_Addr[31:ADDR_W+2], mem.Mem_Addr[1:0]};

  // Next-state: a write wins over a simultaneous read, which is simply dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_write  = 1'b0;
    do_read   = 1'b0;
    capture   = 1'b0;
    ram_idx   = rd_idx_q;
    case (state)
      S_IDLE: begin
        ram_idx = req_idx;
        if (mem.MemWrite) begin
          do_write = 1'b1;
          if (LAT_V != 4'd0) begin
            state_nxt = S_BUSY;
            cnt_nxt   = LAT_V;
          end
        end else if (mem.MemRead) begin
          do_read = 1'b1;
          if (LAT_V == 4'd0) begin
            state_nxt = S_RESP;
            capture   = 1'b1;
          end else begin
            state_nxt = S_RLAT;
            cnt_nxt   = LAT_V;
          end
        end
      end
      S_BUSY: begin
        cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = S_IDLE;
      end
      S_RLAT: begin
        cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = S_RESP;
          capture   = 1'b1;
        end
      end
      S_RESP: begin
        if (mem.Read_data_Ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      rd_idx_q <= '0;
      rdr      <= 32'd0;
      acc_cnt  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (do_read) rd_idx_q <= req_idx;
      if (capture) rdr <= ram[ram_idx];
      if (do_write || do_read) acc_cnt <= acc_cnt + 32'd1;
    end
  end

  // RAM contents are deliberately left out of reset so they survive rst.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (mem.Write_strb[i]) ram[req_idx][8*i +: 8] <= mem.Write_data[8*i +: 8];
      end
    end
  end

  assign mem.Mem_Req_Ready   = (state == S_IDLE) && !rst;
  assign mem.Read_data_Valid = (state == S_RESP);
  assign mem.Read_data       = rdr;
  assign mem.Acc_Cnt         = acc_cnt;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks of data_mem_responder, one instance at
// LAT=2 and one at LAT=0, against a word-array reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 2;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  strb  = 4'd0;
  logic        wr    = 1'b0;
  logic        rd    = 1'b0;
  logic        rdy   = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] mem_m [2][1024];
  logic [3:0]  known [2][1024];
  int          acc_m [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder_if if2 ();
  data_mem_responder_if if0 ();

  // Only the selected instance sees requests; the other one idles.
  assign if2.Mem_Addr        = addr;
  assign if2.Write_data      = wdata;
  assign if2.Write_strb      = strb;
  assign if2.MemWrite        = wr  && (sel == 2);
  assign if2.MemRead         = rd  && (sel == 2);
  assign if2.Read_data_Ready = rdy && (sel == 2);
  assign if0.Mem_Addr        = addr;
  assign if0.Write_data      = wdata;
  assign if0.Write_strb      = strb;
  assign if0.MemWrite        = wr  && (sel == 0);
  assign if0.MemRead         = rd  && (sel == 0);
  assign if0.Read_data_Ready = rdy && (sel == 0);

  logic        ready_o, valid_o;
  logic [31:0] rdata_o, acc_o;
  assign ready_o = (sel == 2) ? if2.Mem_Req_Ready   : if0.Mem_Req_Ready;
  assign valid_o = (sel == 2) ? if2.Read_data_Valid : if0.Read_data_Valid;
  assign rdata_o = (sel == 2) ? if2.Read_data       : if0.Read_data;
  assign acc_o   = (sel == 2) ? if2.Acc_Cnt         : if0.Acc_Cnt;

  data_mem_responder #(.ADDR_W(10), .LAT(2)) dut2 (.clk(clk), .rst(rst), .mem(if2.slave));
  data_mem_responder #(.ADDR_W(10), .LAT(0)) dut0 (.clk(clk), .rst(rst), .mem(if0.slave));

  function automatic int midx();
    return (sel == 2) ? 0 : 1;
  endfunction

  function automatic int lat_of();
    return (sel == 2) ? 2 : 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check_output("req_ready_wait", {31'd0, ready_o}, 32'd1);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit with_read);
    int m = midx();
    int w = widx(a);
    wait_ready();
    addr = a; wdata = d; strb = s; wr = 1'b1; rd = with_read;
    step();
    wr = 1'b0; rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) mem_m[m][w][8*i +: 8] = d[8*i +: 8];
    end
    known[m][w] = known[m][w] | s;
    acc_m[m]++;
    for (int c = 1; c <= lat_of(); c++) begin
      check_output("store_busy_ready", {31'd0, ready_o}, 32'd0);
      check_output("store_no_valid", {31'd0, valid_o}, 32'd0);
      step();
    end
    check_output("store_ready_back", {31'd0, ready_o}, 32'd1);
    check_output("store_no_valid", {31'd0, valid_o}, 32'd0);
    check_output("store_acc", acc_o, 32'(acc_m[m]));
  endtask

  task automatic do_load(input logic [31:0] a, input int hold,
                         output logic [31:0] got, output int acc_cyc);
    int m = midx();
    logic [31:0] exp;
    wait_ready();
    exp = mem_m[m][widx(a)];
    addr = a; rd = 1'b1; acc_cyc = cyc;
    step();
    rd = 1'b0;
    acc_m[m]++;
    for (int c = 1; c <= lat_of(); c++) begin
      check_output("load_lat_ready", {31'd0, ready_o}, 32'd0);
      check_output("load_lat_valid", {31'd0, valid_o}, 32'd0);
      step();
    end
    got = rdata_o;
    check_output("load_valid", {31'd0, valid_o}, 32'd1);
    check_output("load_data", rdata_o, exp);
    for (int h = 0; h < hold; h++) begin
      rdy = 1'b0;
      step();
      check_output("bp_valid", {31'd0, valid_o}, 32'd1);
      check_output("bp_ready", {31'd0, ready_o}, 32'd0);
      check_output("bp_data", rdata_o, exp);
    end
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    check_output("load_done_ready", {31'd0, ready_o}, 32'd1);
    check_output("load_done_valid", {31'd0, valid_o}, 32'd0);
    check_output("load_rdr_held", rdata_o, exp);
    check_output("load_acc", acc_o, 32'(acc_m[m]));
  endtask

  initial begin
    logic [31:0] got, d;
    int          t0, t1, w;
    bit          found;

    for (int m = 0; m < 2; m++) begin
      acc_m[m] = 0;
      for (int i = 0; i < 1024; i++) known[m][i] = 4'd0;
    end

    // Reset values on both instances
    repeat (3) step();
    for (int s = 0; s <= 2; s += 2) begin
      sel = s;
      #1;
      check_output("rst_ready", {31'd0, ready_o}, 32'd0);
      check_output("rst_valid", {31'd0, valid_o}, 32'd0);
      check_output("rst_rdata", rdata_o, 32'd0);
      check_output("rst_acc", acc_o, 32'd0);
    end
    sel = 2;
    rst = 1'b0;
    rdy = 1'b1;
    #1;
    check_output("first_cycle_ready", {31'd0, ready_o}, 32'd1);
    step();
    rdy = 1'b0;

    // LAT=2 basic store then load
    do_store(32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
    do_load(32'h100, 0, got, t0);
    check_output("basic_load", got, 32'hDEADBEEF);

    // Lane merge
    do_store(32'h104, 32'h11223344, 4'hF, 1'b0);
    do_store(32'h105, 32'h0000AA00, 4'b0010, 1'b0);
    do_load(32'h104, 0, got, t0);
    check_output("lane_merge", got, 32'h1122AA44);

    // Simultaneous read+write: write lands, no response follows
    do_store(32'h200, 32'h5A5A5A5A, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_output("dropped_read_no_valid", {31'd0, valid_o}, 32'd0);
      step();
    end
    do_load(32'h200, 0, got, t0);
    check_output("simul_write_landed", got, 32'h5A5A5A5A);

    // Reset while the load is in its latency window
    wait_ready();
    addr = 32'h100; rd = 1'b1;
    step();
    rd = 1'b0;
    rst = 1'b1;
    #1;
    check_output("midrst_ready", {31'd0, ready_o}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    acc_m[0] = 0;
    acc_m[1] = 0;
    check_output("post_rst_ready", {31'd0, ready_o}, 32'd1);
    check_output("post_rst_rdata", rdata_o, 32'd0);
    check_output("post_rst_acc", acc_o, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check_output("post_rst_no_valid", {31'd0, valid_o}, 32'd0);
      step();
    end

    // Back-pressure for 5 cycles; RAM survived the reset
    do_load(32'h100, 5, got, t0);
    check_output("bp_survives_rst", got, 32'hDEADBEEF);
    check_output("bp_acc_one", acc_o, 32'd1);

    // LAT=0: back-to-back stores, aliased loads at 2-cycle spacing
    sel = 0;
    #1;
    t1 = cyc;
    for (int k = 0; k < 8; k++) begin
      do_store(32'(4 * k), $urandom, 4'hF, 1'b0);
    end
    check_output("b2b_store_cycles", 32'(cyc - t1), 32'd8);
    do_load(32'h1000, 0, got, t1);
    for (int k = 1; k < 8; k++) begin
      do_load(32'h1000 + 32'(4 * k), 0, got, t0);
      check_output("load_spacing", 32'(t0 - t1), 32'd2);
      t1 = t0;
    end

    // Randomized mix across both latencies
    for (int n = 0; n < 80; n++) begin
      sel = ($urandom_range(0, 1) == 0) ? 0 : 2;
      #1;
      found = 1'b0;
      w = 0;
      if ($urandom_range(0, 1) == 1) begin
        for (int tr = 0; tr < 10 && !found; tr++) begin
          w = $urandom_range(0, 31);
          found = (known[midx()][w] == 4'hF);
        end
      end
      d = ($urandom & 32'hFFFFF000) | 32'(w << 2) | ($urandom & 32'h3);
      if (found) begin
        do_load(d, $urandom_range(0, 3), got, t0);
      end else begin
        w = $urandom_range(0, 31);
        d = ($urandom & 32'hFFFFF000) | 32'(w << 2) | ($urandom & 32'h3);
        do_store(d, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 3) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the turbo RV32 pipeline: the slave end of the memory request/response channels driven by the memory-access stage. It accepts word-aligned load/store requests on a valid/ready request channel, applies byte-strobed writes to an internal word RAM, and returns full 32-bit read words on a valid/ready response channel. The response latency is programmable so that stall paths in the pipeline can be exercised. It is used as the data-side memory in simulation and in FPGA-resident configurations.

## Interface
- ADDR_W, 10, word-address width; RAM depth is 2^ADDR_W 32-bit words
- LAT, 2, extra latency cycles per request, 0..15
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- Mem_Addr  in  32  byte address; bits [1:0] are ignored
- MemWrite  in  1  store request valid
- Write_data  in  32  store data, lane-aligned
- Write_strb  in  4  byte-lane enables; bit i enables Write_data[8i+7:8i]
- MemRead  in  1  load request valid
- Mem_Req_Ready  out  1  request accepted when (MemRead|MemWrite) && Mem_Req_Ready
- Read_data  out  32  full word read; the initiator extracts bytes and halfwords
- Read_data_Valid  out  1  response valid
- Read_data_Ready  in  1  response accepted when Valid && Ready
- Acc_Cnt  out  32  count of accepted requests, for performance checks

## Operation
- Word index is Mem_Addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses alias modulo 2^ADDR_W words.
- The RAM is not reset; its contents survive rst.
- FSM states: S_IDLE, S_BUSY, S_RLAT, S_RESP. Reset state is S_IDLE.
- S_IDLE: Mem_Req_Ready=1.
  - MemWrite: write the strobed lanes; unstrobed lanes are unchanged. Next state is S_BUSY with cnt=LAT, or stay in S_IDLE if LAT=0.
  - MemWrite and MemRead together: the write is served and the read is ignored (dropped, not queued).
  - MemRead only: latch the word index. Next state is S_RLAT with cnt=LAT, or S_RESP if LAT=0 (data captured in the same edge).
- S_BUSY: Ready=0. cnt decrements each cycle; at cnt==1 (or if entered with 0) go to S_IDLE.
- S_RLAT: Ready=0. Same countdown. On leaving, the RAM word is captured into RDR and the state moves to S_RESP.
- S_RESP: Read_data_Valid=1 and Ready=0. RDR is held stable until Read_data_Ready=1, then the state returns to S_IDLE.
- Read_data equals RDR at all times, including outside S_RESP.
- A Read_data_Ready that is high outside S_RESP is legal and ignored. The initiator raises it for one cycle after reset.
- Acc_Cnt increments by 1 on each accepted request and wraps at 2^32. A dropped read counts as part of its write, not separately.

## Timing
- Reset values:
  - Mem_Req_Ready=0 while rst=1, then 1 in the first cycle after rst.
  - Read_data_Valid=0, Read_data=0 (RDR cleared), Acc_Cnt=0, cnt=0.
- Reset mid-operation (S_BUSY/S_RLAT/S_RESP) aborts any pending response. No Valid appears afterwards.
- Cycle 0 is the acceptance cycle.
- Load: Valid first high in cycle LAT+1, and holds until the handshake cycle inclusive. Mem_Req_Ready is high again in the cycle after the handshake.
- Store: RAM is updated at the end of cycle 0. Ready is low in cycles 1..LAT and high in cycle LAT+1. With LAT=0, Ready stays high, so back-to-back stores run at 1 per cycle.
- Minimum load-to-load spacing is LAT+2 cycles with Read_data_Ready tied high.
- A store followed by a load to the same word returns the new data, whatever the latency.
- All outputs are registered or decoded directly from state, with no combinational path from inputs to outputs except through rst on Mem_Req_Ready.

## Test plan
- LAT=2, store 0xDEADBEEF strb 1111 at 0x100, then load 0x100:
  - Ready is low for 2 cycles after the store.
  - Valid rises 3 cycles after the load is accepted; Read_data=0xDEADBEEF.
- Lane merge:
  - Store 0x11223344 strb 1111 to 0x104.
  - Store 0x0000AA00 strb 0010 to 0x105.
  - Load 0x104 must return 0x1122AA44.
- Back-pressure: Read_data_Ready held low for 5 cycles in S_RESP.
  - Valid and Read_data stay stable and Mem_Req_Ready stays 0.
  - The handshake occurs on the first Ready=1; Acc_Cnt=1.
- Simultaneous MemRead and MemWrite to 0x200 (data 0x5A5A5A5A):
  - The write lands, no Valid follows, and Acc_Cnt increments by 1.
- Reset mid-operation: rst asserted during S_RLAT.
  - Valid never rises and Ready=1 in the cycle after rst drops.
  - A subsequent load to the earlier stored address still returns the pre-reset contents.
- LAT=0 and aliasing:
  - 8 back-to-back stores are each accepted in consecutive cycles.
  - Address 0x1000+4k (ADDR_W=10) aliases word k; load spacing is exactly 2 cycles.
